// File: rtl/chip_clk_seq.sv
// Colour-clock source selector: synchronises and debounces the chip-model request,
// then sequences CPU reset, PLL reset and lock acquisition around each mux switchover.
module chip_clk_seq #(
    parameter int NUM_CHIPS       = 4,
    parameter int SEL_W           = 2,
    parameter int DEFAULT_CHIP    = 0,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1024,
    parameter int HOLD_CYCLES     = 64,
    parameter int PLLRST_CYCLES   = 16,
    parameter int LOCK_TIMEOUT    = 65535,
    parameter int MAX_RETRY       = 3
) (
    input  logic             clk_col4x_pal,
    input  logic             rst,
    input  logic [SEL_W-1:0] chip_req,
    input  logic             pll_locked,
    output logic [SEL_W-1:0] mux_sel,
    output logic             pll_reset,
    output logic             cpu_reset,
    output logic             busy,
    output logic             lock_err,
    output logic [7:0]       switch_count
);

    localparam int CNT_MAX_AB = (DEBOUNCE_CYCLES > LOCK_TIMEOUT) ? DEBOUNCE_CYCLES : LOCK_TIMEOUT;
    localparam int CNT_MAX_CD = (HOLD_CYCLES > PLLRST_CYCLES) ? HOLD_CYCLES : PLLRST_CYCLES;
    localparam int CNT_MAX    = (CNT_MAX_AB > CNT_MAX_CD) ? CNT_MAX_AB : CNT_MAX_CD;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);
    localparam int RETRY_W    = $clog2(MAX_RETRY + 1);

    localparam logic [CNT_W-1:0]   DB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]   PLLRST_LAST = CNT_W'(PLLRST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIM   = RETRY_W'(MAX_RETRY);
    localparam logic [SEL_W:0]     NUM_CHIPS_W = (SEL_W + 1)'(NUM_CHIPS);
    localparam logic [SEL_W-1:0]   DEF_SEL     = SEL_W'(DEFAULT_CHIP);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DEBOUNCE,
        ST_HOLD_PRE,
        ST_PLLRST,
        ST_WAIT_LOCK,
        ST_HOLD_POST,
        ST_FAIL
    } state_t;

    // Input synchronisers; nothing else looks at chip_req or pll_locked.
    logic [SYNC_STAGES-1:0][SEL_W-1:0] req_pipe;
    logic [SYNC_STAGES-1:0]            lock_pipe;
    logic [SEL_W-1:0]                  req_s;
    logic                              lock_s;
    logic                              req_valid;

    always_ff @(posedge clk_col4x_pal or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                req_pipe[i]  <= DEF_SEL;
                lock_pipe[i] <= 1'b0;
            end
        end else begin
            req_pipe[0]  <= chip_req;
            lock_pipe[0] <= pll_locked;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                req_pipe[i]  <= req_pipe[i-1];
                lock_pipe[i] <= lock_pipe[i-1];
            end
        end
    end

    assign req_s     = req_pipe[SYNC_STAGES-1];
    assign lock_s    = lock_pipe[SYNC_STAGES-1];
    assign req_valid = ({1'b0, req_s} < NUM_CHIPS_W);

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [RETRY_W-1:0] retry_reg, retry_next;
    logic [RETRY_W-1:0] retry_inc;
    logic [SEL_W-1:0]   cap_reg, cap_next;
    logic [SEL_W-1:0]   tgt_reg, tgt_next;
    logic               pend_reg, pend_next;
    logic               lock_err_reg, lock_err_next;
    logic [7:0]         count_reg, count_next;
    logic [SEL_W-1:0]   mux_sel_reg;
    logic               pll_reset_reg, cpu_reset_reg, busy_reg;

    assign retry_inc = retry_reg + 1'b1;

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        retry_next    = retry_reg;
        cap_next      = cap_reg;
        tgt_next      = tgt_reg;
        pend_next     = pend_reg;
        lock_err_next = lock_err_reg;
        count_next    = count_reg;

        case (state_reg)
            ST_IDLE: begin
                // Lock loss re-runs the switch sequence with tgt already equal to mux_sel.
                if (!lock_s) begin
                    state_next = ST_HOLD_PRE;
                    cnt_next   = '0;
                end else if (req_valid && (req_s != mux_sel_reg)) begin
                    state_next = ST_DEBOUNCE;
                    cnt_next   = '0;
                    cap_next   = req_s;
                end
            end
            ST_DEBOUNCE: begin
                if (!req_valid || (req_s != cap_reg) || (req_s == mux_sel_reg)) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else if (cnt_reg == DB_LAST) begin
                    state_next = ST_HOLD_PRE;
                    cnt_next   = '0;
                    tgt_next   = req_s;
                    pend_next  = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_HOLD_PRE: begin
                if (cnt_reg >= HOLD_LAST) begin
                    state_next = ST_PLLRST;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_PLLRST: begin
                if (cnt_reg >= PLLRST_LAST) begin
                    state_next = ST_WAIT_LOCK;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    // The cycle that sees lock counts as the first post-lock hold cycle.
                    state_next = ST_HOLD_POST;
                    cnt_next   = CNT_W'(1);
                end else if (cnt_reg >= TO_LAST) begin
                    cnt_next   = '0;
                    retry_next = retry_inc;
                    if (retry_inc < RETRY_LIM) begin
                        state_next = ST_PLLRST;
                    end else begin
                        state_next    = ST_FAIL;
                        lock_err_next = 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_HOLD_POST: begin
                if (!lock_s) begin
                    state_next = ST_PLLRST;
                    cnt_next   = '0;
                end else if (cnt_reg >= HOLD_LAST) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                    retry_next = '0;
                    pend_next  = 1'b0;
                    if (pend_reg && (count_reg != 8'hFF)) begin
                        count_next = count_reg + 8'd1;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_FAIL: begin
                if (req_valid && (req_s != mux_sel_reg)) begin
                    state_next = ST_DEBOUNCE;
                    cnt_next   = '0;
                    cap_next   = req_s;
                    retry_next = '0;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_col4x_pal or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_PLLRST;
            cnt_reg       <= '0;
            retry_reg     <= '0;
            cap_reg       <= DEF_SEL;
            tgt_reg       <= DEF_SEL;
            pend_reg      <= 1'b0;
            lock_err_reg  <= 1'b0;
            count_reg     <= '0;
            mux_sel_reg   <= DEF_SEL;
            pll_reset_reg <= 1'b1;
            cpu_reset_reg <= 1'b1;
            busy_reg      <= 1'b1;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            retry_reg     <= retry_next;
            cap_reg       <= cap_next;
            tgt_reg       <= tgt_next;
            pend_reg      <= pend_next;
            lock_err_reg  <= lock_err_next;
            count_reg     <= count_next;
            // Outputs follow the next state so they line up with state_reg with no comb path.
            if (state_next == ST_PLLRST) begin
                mux_sel_reg <= tgt_reg;
            end
            pll_reset_reg <= (state_next == ST_PLLRST);
            cpu_reset_reg <= (state_next != ST_IDLE) && (state_next != ST_DEBOUNCE);
            busy_reg      <= (state_next != ST_IDLE);
        end
    end

    assign mux_sel      = mux_sel_reg;
    assign pll_reset    = pll_reset_reg;
    assign cpu_reset    = cpu_reset_reg;
    assign busy         = busy_reg;
    assign lock_err     = lock_err_reg;
    assign switch_count = count_reg;

endmodule

// File: doc/chip_clk_seq.md
Name: chip_clk_seq

Overview:
- Parametrised successor to the board-level chip/colour-clock selection logic.
- Takes an asynchronous chip-model request (one of NUM_CHIPS colour-clock sources), synchronises and debounces it, and drives the clock-mux select.
- Sequences a safe switchover: CPU held in reset, PLL reset, wait for lock with timeout/retry, then CPU released.
- Sits at top level between the standard switch / config logic and the BUFGMUX, clockgen PLL and cpu_reset pin.

Parameters:
- NUM_CHIPS, 4, number of selectable chip models / clock sources (2..16).
- SEL_W, 2, width of select buses; must satisfy 2^SEL_W >= NUM_CHIPS.
- DEFAULT_CHIP, 0, mux_sel value out of reset.
- SYNC_STAGES, 2, synchroniser depth for chip_req and pll_locked (>=2).
- DEBOUNCE_CYCLES, 1024, stable-request cycles required before a switch.
- HOLD_CYCLES, 64, cycles cpu_reset is asserted before the mux changes, and again after lock.
- PLLRST_CYCLES, 16, width of the pll_reset pulse.
- LOCK_TIMEOUT, 65535, cycles to wait for lock per attempt.
- MAX_RETRY, 3, lock attempts before error.

Ports:
- clk_col4x_pal  in  1  free-running sequencer clock; never muxed.
- rst  in  1  asynchronous, active-high reset.
- chip_req  in  SEL_W  requested chip model; asynchronous, may bounce.
- pll_locked  in  1  clockgen PLL lock; asynchronous.
- mux_sel  out  SEL_W  clock-mux select; registered.
- pll_reset  out  1  clockgen PLL reset, active high.
- cpu_reset  out  1  6510 reset hold, active high.
- busy  out  1  high whenever state != IDLE.
- lock_err  out  1  sticky; set when MAX_RETRY attempts fail.
- switch_count  out  8  completed switchovers; saturates at 255.

Behaviour:
- Reset values: mux_sel=DEFAULT_CHIP, pll_reset=1, cpu_reset=1, busy=1, lock_err=0, switch_count=0, state=PLLRST, retry=0. All counters are cleared.
- req_s is chip_req after SYNC_STAGES flops. lock_s is pll_locked after SYNC_STAGES flops. No other logic samples the raw inputs.
- A request is valid when req_s < NUM_CHIPS. Invalid values are ignored, clear the debounce counter and never change mux_sel.
- States:
  - IDLE: cpu_reset=0, pll_reset=0. If req_s is valid and differs from mux_sel, go to DEBOUNCE with cnt=0.
    - If lock_s falls while in IDLE, go to HOLD_PRE: same path as a switch, but mux_sel is unchanged.
  - DEBOUNCE: cnt increments each cycle while req_s is equal to its captured value.
    - A change in req_s, or an invalid value, returns the state to IDLE.
    - When cnt==DEBOUNCE_CYCLES-1, latch tgt=req_s and go to HOLD_PRE.
    - If req_s equals mux_sel again, return to IDLE with no switch.
  - HOLD_PRE: cpu_reset=1 for HOLD_CYCLES cycles, then go to PLLRST.
  - PLLRST: mux_sel=tgt is registered on the first cycle of this state. pll_reset=1 for PLLRST_CYCLES cycles, then go to WAIT_LOCK.
  - WAIT_LOCK: pll_reset=0.
    - When lock_s=1, go to HOLD_POST.
    - If LOCK_TIMEOUT cycles elapse, increment retry. If retry<MAX_RETRY, return to PLLRST. Otherwise set lock_err and go to FAIL.
  - HOLD_POST: cpu_reset=1 for HOLD_CYCLES cycles, then cpu_reset=0. switch_count increments (saturating), retry clears, state goes to IDLE.
    - If lock_s drops during HOLD_POST, go to PLLRST; this does not consume a retry.
  - FAIL: cpu_reset=1, pll_reset=0.
    - A valid request different from mux_sel restarts DEBOUNCE with retry=0.
    - lock_err clears only on rst.
- Request changes from HOLD_PRE through HOLD_POST are ignored. IDLE re-evaluates them after completion.
- Post-reset flow: PLLRST with tgt=DEFAULT_CHIP, then WAIT_LOCK, HOLD_POST, IDLE. switch_count is not incremented for this boot sequence.
- Reset mid-operation returns to the reset values immediately (asynchronous).
- The counter width is sized for max(DEBOUNCE_CYCLES, LOCK_TIMEOUT, HOLD_CYCLES). One shared down-counter is permitted.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Test parameters for all scenarios: DEBOUNCE=8, HOLD=4, PLLRST=2, TIMEOUT=20, MAX_RETRY=2, NUM_CHIPS=3.
- Boot: rst 1→0, pll_locked=1 after 10 cycles → mux_sel=0 throughout; cpu_reset falls exactly HOLD=4 cycles after lock_s rises; switch_count=0; busy=0.
- Clean switch: chip_req 0→2 held → mux_sel=2 exactly SYNC+8+4 cycles after the edge; pll_reset high 2 cycles; drop/raise lock → cpu_reset released 4 cycles after lock_s; switch_count=1.
- Bounce: chip_req toggles 0↔1 every 5 cycles for 100 cycles, then settles at 0 → mux_sel stays 0, cpu_reset never asserts, switch_count unchanged.
- Invalid request: chip_req=3 held 50 cycles → no state change; busy stays 0.
- Lock failure: request 1, pll_locked held 0 → two pll_reset pulses 20 cycles apart, then lock_err=1, cpu_reset=1, FAIL; new request 2 with lock → recovers, lock_err stays 1.
- Async reset during WAIT_LOCK → next sample shows mux_sel=0, cpu_reset=1, pll_reset=1, switch_count=0.
